// File: rtl/joy_dir_arb.sv
// +----------------------------------------------------------------------------+
// | joy_dir_arb                                                                |
// | Multi-player joystick direction arbiter: pass / last-pressed / 4-way /     |
// | opposing-cancel. Define JOYDIR_DEBOUNCE_EN to enable input debounce.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module joy_dir_arb #(
  parameter int PLAYERS    = 2,
  parameter int DEB_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           mode,
  input  logic [PLAYERS-1:0]   dis,
  input  logic [4*PLAYERS-1:0] indir,
  output logic [4*PLAYERS-1:0] outdir,
  output logic [PLAYERS-1:0]   dir_chg
);

  localparam logic [1:0] c_MODE_PASS = 2'd0;
  localparam logic [1:0] c_MODE_LAST = 2'd1;
  localparam logic [1:0] c_MODE_4WAY = 2'd2;
  localparam logic [1:0] c_MODE_SOCD = 2'd3;

  if (DEB_CYCLES < 1 || DEB_CYCLES > 65535) begin : g_bad_deb_cycles
    $error("joy_dir_arb: DEB_CYCLES must be in 1..65535");
  end

  // One-hot of the highest set bit: up > down > left > right.
  function automatic logic [3:0] f_top1(input logic [3:0] v);
    f_top1 = 4'b0000;
    if (v[3])      f_top1 = 4'b1000;
    else if (v[2]) f_top1 = 4'b0100;
    else if (v[1]) f_top1 = 4'b0010;
    else if (v[0]) f_top1 = 4'b0001;
  endfunction

  logic [1:0] r_mode_q;
  logic       w_mode_chg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_mode_q <= 2'd0;
    else          r_mode_q <= mode;
  end

  assign w_mode_chg = (mode != r_mode_q);

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [3:0] r_s1;
    logic [3:0] r_s2;
    logic [3:0] w_stb;
    logic [3:0] r_stb_q;
    logic [3:0] w_np;
    logic [3:0] r_mask;
    logic [3:0] w_nxt;
    logic [3:0] r_out;
    logic       r_chg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_s1 <= 4'b0000;
        r_s2 <= 4'b0000;
      end else begin
        r_s1 <= indir[4*p +: 4];
        r_s2 <= r_s1;
      end
    end

`ifdef JOYDIR_DEBOUNCE_EN
    localparam logic [15:0] c_DEB_LAST = 16'(DEB_CYCLES - 1);

    for (genvar b = 0; b < 4; b++) begin : g_deb
      logic [15:0] r_cnt;
      logic        r_stb;

      // A bit is accepted only after it has differed for DEB_CYCLES cycles.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt <= 16'd0;
          r_stb <= 1'b0;
        end else if (r_s2[b] == r_stb) begin
          r_cnt <= 16'd0;
        end else if (r_cnt == c_DEB_LAST) begin
          r_stb <= r_s2[b];
          r_cnt <= 16'd0;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end

      assign w_stb[b] = r_stb;
    end
`else
    assign w_stb = r_s2;
`endif

    assign w_np = w_stb & ~r_stb_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_stb_q <= 4'b0000;
        r_mask  <= 4'b1111;
      end else begin
        r_stb_q <= w_stb;
        if (dis[p] || w_mode_chg)
          r_mask <= 4'b1111;
        else if (w_np != 4'b0000)
          r_mask <= f_top1(w_np);
        else if ((w_stb & r_mask) == 4'b0000)
          r_mask <= 4'b1111;
      end
    end

    always_comb begin
      w_nxt = w_stb;
      case (mode)
        c_MODE_PASS: w_nxt = w_stb;
        c_MODE_LAST: w_nxt = w_stb & r_mask;
        c_MODE_4WAY: w_nxt = f_top1(w_stb & r_mask);
        c_MODE_SOCD: begin
          if (w_stb[3] && w_stb[2]) w_nxt[3:2] = 2'b00;
          if (w_stb[1] && w_stb[0]) w_nxt[1:0] = 2'b00;
        end
        default: w_nxt = w_stb;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_out <= 4'b0000;
        r_chg <= 1'b0;
      end else begin
        r_out <= w_nxt;
        r_chg <= (w_nxt != r_out);
      end
    end

    assign outdir[4*p +: 4] = r_out;
    assign dir_chg[p]       = r_chg;
  end

endmodule

`default_nettype wire
